// File: rtl/dsp_seq_pkg.sv
// Shared types and constants for the DSP48A1 multiply-accumulate sequencer.
package dsp_seq_pkg;

    localparam int unsigned DATA_W     = 18;
    localparam int unsigned P_W        = 48;
    localparam int unsigned PREADD_BIT = 4;

    // X=M with Z=0 for the first beat; X=M with Z=P to accumulate the rest
    localparam logic [7:0] OPMODE_FIRST = 8'h01;
    localparam logic [7:0] OPMODE_ACC   = 8'h09;

    typedef enum logic [1:0] {StIdle, StFeed, StDrain, StDone} state_t;

    function automatic logic [7:0] beat_opmode(input logic first, input logic preadd);
        logic [7:0] op;
        op             = first ? OPMODE_FIRST : OPMODE_ACC;
        op[PREADD_BIT] = preadd;
        return op;
    endfunction

endpackage

// File: rtl/dsp_seq_pipe.sv
// Per-beat valid/first shift register that times the DSP M, OPMODE and P enables.
// Honours PRE_ADD_EN by setting the pre-adder OPMODE bit.
module dsp_seq_pipe
    import dsp_seq_pkg::*;
#(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       valid_i,
    input  logic       first_i,
    output logic       cem_o,
    output logic       ceopmode_o,
    output logic       cep_o,
    output logic [7:0] opmode_o,
    output logic       p_upd_o,
    output logic       inflight_o
);

`ifdef PRE_ADD_EN
    localparam logic PreAdd = 1'b1;
`else
    localparam logic PreAdd = 1'b0;
`endif

    logic [MUL_LAT:0]   vld_q, vld_d;
    // The first flag is only consumed at the OPMODE stage, so it stops there.
    logic [MUL_LAT-2:0] fst_q, fst_d;

    always_comb begin
        vld_d    = vld_q << 1;
        vld_d[0] = valid_i;
        fst_d    = fst_q << 1;
        fst_d[0] = valid_i & first_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
            fst_q <= '0;
        end else begin
            vld_q <= vld_d;
            fst_q <= fst_d;
        end
    end

    always_comb begin
        cem_o      = vld_q[MUL_LAT-2];
        ceopmode_o = vld_q[MUL_LAT-2];
        cep_o      = vld_q[MUL_LAT-1];
        p_upd_o    = vld_q[MUL_LAT];
        inflight_o = |vld_q[MUL_LAT-1:0];
        opmode_o   = '0;
        if (vld_q[MUL_LAT-2]) begin
            opmode_o = beat_opmode(fst_q[MUL_LAT-2], PreAdd);
        end
    end

endmodule

// File: rtl/dsp48a1_mac_seq.sv
// Dot-product sequencer driving a Spartan6 DSP48A1 as a MAC engine.
// Optional pre-adder input IN_D is enabled by defining PRE_ADD_EN.
module dsp48a1_mac_seq
    import dsp_seq_pkg::*;
#(
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned LEN_W   = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [LEN_W-1:0]  LEN,
    output logic              BUSY,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_A,
    input  logic [DATA_W-1:0] IN_B,
`ifdef PRE_ADD_EN
    input  logic [DATA_W-1:0] IN_D,
`endif
    output logic [DATA_W-1:0] DSP_A,
    output logic [DATA_W-1:0] DSP_B,
    output logic [DATA_W-1:0] DSP_D,
    output logic [7:0]        DSP_OPMODE,
    output logic              DSP_CEA,
    output logic              DSP_CEB,
    output logic              DSP_CEM,
    output logic              DSP_CEP,
    output logic              DSP_CEOPMODE,
    output logic              DSP_RST,
    input  logic [P_W-1:0]    DSP_P,
    output logic [P_W-1:0]    RES,
    output logic              RES_VALID
);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               first_q, first_d;
    logic [P_W-1:0]     res_q, res_d;
    logic               accept;
    logic               p_upd;
    logic               inflight;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            first_q <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        res_d   = res_q;
        accept  = IN_VALID && (state_q == StFeed);
        unique case (state_q)
            StIdle: begin
                if (START) begin
                    if (LEN == '0) begin
                        res_d   = '0;
                        state_d = StDone;
                    end else begin
                        cnt_d   = LEN;
                        first_d = 1'b1;
                        state_d = StFeed;
                    end
                end
            end
            StFeed: begin
                if (accept) begin
                    cnt_d   = cnt_q - LEN_W'(1);
                    first_d = 1'b0;
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // Last product has landed in P once nothing is left upstream of it.
                if (p_upd && !inflight) begin
                    res_d   = DSP_P;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    dsp_seq_pipe #(
        .MUL_LAT (MUL_LAT)
    ) u_pipe (
        .clk_i      (CLK),
        .rst_i      (RST),
        .valid_i    (accept),
        .first_i    (first_q),
        .cem_o      (DSP_CEM),
        .ceopmode_o (DSP_CEOPMODE),
        .cep_o      (DSP_CEP),
        .opmode_o   (DSP_OPMODE),
        .p_upd_o    (p_upd),
        .inflight_o (inflight)
    );

    always_comb begin
        BUSY      = (state_q != StIdle);
        IN_READY  = (state_q == StFeed);
        RES_VALID = (state_q == StDone);
        RES       = res_q;
        DSP_RST   = RST;
        DSP_CEA   = accept;
        DSP_CEB   = accept;
        DSP_A     = IN_A;
        DSP_B     = IN_B;
`ifdef PRE_ADD_EN
        DSP_D     = IN_D;
`else
        DSP_D     = '0;
`endif
    end

endmodule

// File: tb/tb_dsp48a1_mac_seq.sv
// Self-checking bench: sequencer driving a behavioural DSP48A1, checked against a dot-product model.
module tb_dsp48a1_mac_seq;

    localparam int unsigned MUL_LAT = 2;
    localparam int unsigned LEN_W   = 8;
`ifdef PRE_ADD_EN
    localparam logic [7:0] OP_F = 8'h11;
    localparam logic [7:0] OP_A = 8'h19;
`else
    localparam logic [7:0] OP_F = 8'h01;
    localparam logic [7:0] OP_A = 8'h09;
`endif

    logic        CLK = 1'b0;
    logic        RST, START, IN_VALID;
    logic [7:0]  LEN;
    logic [17:0] IN_A, IN_B;
`ifdef PRE_ADD_EN
    logic [17:0] IN_D;
`endif
    logic        BUSY, IN_READY, RES_VALID, DSP_RST;
    logic [17:0] DSP_A, DSP_B, DSP_D;
    logic [7:0]  DSP_OPMODE;
    logic        DSP_CEA, DSP_CEB, DSP_CEM, DSP_CEP, DSP_CEOPMODE;
    logic [47:0] DSP_P, RES;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    dsp48a1_mac_seq #(.MUL_LAT(MUL_LAT), .LEN_W(LEN_W)) dut (
        .CLK(CLK), .RST(RST), .START(START), .LEN(LEN), .BUSY(BUSY),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_A(IN_A), .IN_B(IN_B),
`ifdef PRE_ADD_EN
        .IN_D(IN_D),
`endif
        .DSP_A(DSP_A), .DSP_B(DSP_B), .DSP_D(DSP_D), .DSP_OPMODE(DSP_OPMODE),
        .DSP_CEA(DSP_CEA), .DSP_CEB(DSP_CEB), .DSP_CEM(DSP_CEM), .DSP_CEP(DSP_CEP),
        .DSP_CEOPMODE(DSP_CEOPMODE), .DSP_RST(DSP_RST), .DSP_P(DSP_P),
        .RES(RES), .RES_VALID(RES_VALID)
    );

    // Behavioural DSP48A1: A1/B1 regs, M reg, registered OPMODE, P reg, sync reset.
    logic [17:0] a1_r = '0, b1_r = '0;
    logic [35:0] m_r  = '0;
    logic [7:0]  opm_r = '0;
    logic [47:0] p_r  = '0;
    logic [47:0] x_mux, z_mux;
    assign DSP_P = p_r;

    always_comb begin
        x_mux = (opm_r[1:0] == 2'b01) ? {{12{m_r[35]}}, m_r} : 48'd0;
        z_mux = (opm_r[3:2] == 2'b10) ? p_r : 48'd0;
    end

    always @(posedge CLK) begin
        if (DSP_RST) begin
            a1_r <= '0; b1_r <= '0; m_r <= '0; opm_r <= '0; p_r <= '0;
        end else begin
            if (DSP_CEA) a1_r <= DSP_A;
`ifdef PRE_ADD_EN
            if (DSP_CEB) b1_r <= DSP_D + DSP_B;
`else
            if (DSP_CEB) b1_r <= DSP_B;
`endif
            if (DSP_CEM) m_r <= $signed(a1_r) * $signed(b1_r);
            if (DSP_CEOPMODE) opm_r <= DSP_OPMODE;
            if (DSP_CEP) p_r <= z_mux + x_mux;
        end
    end

    // Event counters, read as before/after deltas by the tests.
    int n_ce = 0, n_cep = 0, n_rv = 0, n_op_first = 0, n_op_acc = 0, n_op_bad = 0;
    logic [7:0] last_opm = '0;
    always @(posedge CLK) begin
        n_ce  <= n_ce + int'(DSP_CEA) + int'(DSP_CEB) + int'(DSP_CEM) + int'(DSP_CEP)
                 + int'(DSP_CEOPMODE);
        n_cep <= n_cep + int'(DSP_CEP);
        n_rv  <= n_rv + int'(RES_VALID);
        if (DSP_CEOPMODE) begin
            last_opm <= DSP_OPMODE;
            if (DSP_OPMODE == OP_F) n_op_first <= n_op_first + 1;
            else if (DSP_OPMODE == OP_A) n_op_acc <= n_op_acc + 1;
            else n_op_bad <= n_op_bad + 1;
        end
    end

    logic [17:0] op_a [256];
    logic [17:0] op_b [256];
    logic [17:0] op_d [256];

    function automatic logic [47:0] ref_dot(input int len);
        longint acc = 0;
        logic [17:0] bd;
        for (int i = 0; i < len; i++) begin
`ifdef PRE_ADD_EN
            bd = op_b[i] + op_d[i];
`else
            bd = op_b[i];
`endif
            acc += longint'($signed(op_a[i])) * longint'($signed(bd));
        end
        return acc[47:0];
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Starts a job and feeds its beats; returns in the cycle after the last accepted beat.
    task automatic feed(input int len, input int gap_at, input int gap_n, input bit rnd,
                        output logic [47:0] p_pre, output logic [47:0] p_post, output bit ok);
        int i = 0;
        int gaps = gap_n;
        int guard = 0;
        p_pre = '0;
        p_post = '0;
        START = 1'b1;
        LEN = 8'(len);
        step();
        START = 1'b0;
        LEN = '0;
        while (i < len && guard < 4000) begin
            guard++;
            if (i == gap_at && gaps > 0) begin
                IN_VALID = 1'b0;
                gaps--;
                if (gaps == 0) p_pre = DSP_P;
            end else if (rnd && $urandom_range(3) == 0) begin
                IN_VALID = 1'b0;
            end else begin
                IN_VALID = 1'b1;
                IN_A = op_a[i];
                IN_B = op_b[i];
`ifdef PRE_ADD_EN
                IN_D = op_d[i];
`endif
                if (i == gap_at && gap_n > 0) p_post = DSP_P;
                if (IN_READY) i++;
            end
            step();
        end
        IN_VALID = 1'b0;
        ok = (i == len);
    endtask

    // Latency is counted in cycles from the last accepted beat; -1 if RES_VALID never came.
    task automatic wait_res(output logic [47:0] res, output int lat,
                            output logic busy_after, output logic rv_after);
        int n = 1;
        while (RES_VALID !== 1'b1 && n < 64) begin
            step();
            n++;
        end
        lat = (RES_VALID === 1'b1) ? n : -1;
        res = RES;
        step();
        busy_after = BUSY;
        rv_after = RES_VALID;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step();
        step();
        checks += 8;
        if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
        if (IN_READY !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", IN_READY); end
        if (RES !== 48'd0) begin failures++; $display("FAIL reset_res got=%0h exp=0", RES); end
        if (RES_VALID !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b exp=0", RES_VALID); end
        if (DSP_OPMODE !== 8'h00) begin failures++; $display("FAIL reset_opmode got=%0h exp=0", DSP_OPMODE); end
        if ({DSP_CEA, DSP_CEB, DSP_CEM, DSP_CEP, DSP_CEOPMODE} !== 5'b0) begin
            failures++; $display("FAIL reset_ce got=%b exp=00000",
                                 {DSP_CEA, DSP_CEB, DSP_CEM, DSP_CEP, DSP_CEOPMODE});
        end
        if (DSP_RST !== 1'b1) begin failures++; $display("FAIL reset_dsp_rst_hi got=%b exp=1", DSP_RST); end
        RST = 1'b0;
        step();
        if (DSP_RST !== 1'b0) begin failures++; $display("FAIL reset_dsp_rst_lo got=%b exp=0", DSP_RST); end
    endtask

    task automatic test_basic();
        logic [47:0] res, pp, pq;
        int lat, cep0, rv0, f0, a0, b0;
        logic busy_after, rv_after;
        bit ok;
        op_a[0] = 18'd15; op_b[0] = 18'd2;
        op_a[1] = 18'd3;  op_b[1] = 18'd4;
        op_a[2] = 18'd10; op_b[2] = 18'd10;
        cep0 = n_cep; rv0 = n_rv; f0 = n_op_first; a0 = n_op_acc; b0 = n_op_bad;
        feed(3, -1, 0, 1'b0, pp, pq, ok);
        wait_res(res, lat, busy_after, rv_after);
        checks += 10;
        if (!ok) begin failures++; $display("FAIL basic_fed got=0 exp=1"); end
        if (res !== ref_dot(3) || res !== 48'd142) begin
            failures++; $display("FAIL basic_res got=%0d exp=142", res);
        end
        if (lat !== int'(MUL_LAT) + 2) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", lat, MUL_LAT + 2); end
        if (busy_after !== 1'b0) begin failures++; $display("FAIL basic_busy_low got=%b exp=0", busy_after); end
        if (rv_after !== 1'b0) begin failures++; $display("FAIL basic_rv_pulse got=%b exp=0", rv_after); end
        if (n_cep - cep0 != 3) begin failures++; $display("FAIL basic_cep_count got=%0d exp=3", n_cep - cep0); end
        if (n_rv - rv0 != 1) begin failures++; $display("FAIL basic_rv_count got=%0d exp=1", n_rv - rv0); end
        if (n_op_first - f0 != 1) begin failures++; $display("FAIL basic_op_first got=%0d exp=1", n_op_first - f0); end
        if (n_op_acc - a0 != 2) begin failures++; $display("FAIL basic_op_acc got=%0d exp=2", n_op_acc - a0); end
        if (n_op_bad - b0 != 0) begin failures++; $display("FAIL basic_op_bad got=%0d exp=0", n_op_bad - b0); end
    endtask

    task automatic test_gap();
        logic [47:0] res, pp, pq;
        int lat, cep0;
        logic busy_after, rv_after;
        bit ok;
        cep0 = n_cep;
        feed(3, 1, 3, 1'b0, pp, pq, ok);
        wait_res(res, lat, busy_after, rv_after);
        checks += 5;
        if (res !== 48'd142) begin failures++; $display("FAIL gap_res got=%0d exp=142", res); end
        if (pp !== 48'd30) begin failures++; $display("FAIL gap_p_before got=%0d exp=30", pp); end
        if (pq !== 48'd30) begin failures++; $display("FAIL gap_p_hold got=%0d exp=30", pq); end
        if (n_cep - cep0 != 3) begin failures++; $display("FAIL gap_cep_count got=%0d exp=3", n_cep - cep0); end
        if (lat !== int'(MUL_LAT) + 2) begin failures++; $display("FAIL gap_latency got=%0d exp=%0d", lat, MUL_LAT + 2); end
    endtask

    task automatic test_len0();
        int ce0;
        ce0 = n_ce;
        START = 1'b1;
        LEN = 8'd0;
        step();
        START = 1'b0;
        checks += 5;
        if (RES_VALID !== 1'b1) begin failures++; $display("FAIL len0_rv got=%b exp=1", RES_VALID); end
        if (RES !== 48'd0) begin failures++; $display("FAIL len0_res got=%0d exp=0", RES); end
        step();
        if (RES_VALID !== 1'b0) begin failures++; $display("FAIL len0_rv_pulse got=%b exp=0", RES_VALID); end
        if (BUSY !== 1'b0) begin failures++; $display("FAIL len0_busy got=%b exp=0", BUSY); end
        if (n_ce - ce0 != 0) begin failures++; $display("FAIL len0_ce got=%0d exp=0", n_ce - ce0); end
    endtask

    task automatic test_back_to_back();
        logic [47:0] res, pp, pq;
        int lat;
        logic busy_after, rv_after;
        bit ok;
        op_a[0] = 18'd7; op_b[0] = 18'd8;
        feed(1, -1, 0, 1'b0, pp, pq, ok);
        wait_res(res, lat, busy_after, rv_after);
        checks += 3;
        if (res !== 48'd56) begin failures++; $display("FAIL b2b_res1 got=%0d exp=56", res); end
        op_a[0] = 18'd1; op_b[0] = 18'd1;
        op_a[1] = 18'd2; op_b[1] = 18'd2;
        feed(2, -1, 0, 1'b0, pp, pq, ok);
        wait_res(res, lat, busy_after, rv_after);
        if (res !== 48'd5) begin failures++; $display("FAIL b2b_res2 got=%0d exp=5", res); end
        if (lat !== int'(MUL_LAT) + 2) begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, MUL_LAT + 2); end
    endtask

    task automatic test_rst_drain();
        logic [47:0] res, pp, pq;
        int lat, rv0;
        logic busy_after, rv_after;
        bit ok;
        op_a[0] = 18'd4; op_b[0] = 18'd5;
        op_a[1] = 18'd6; op_b[1] = 18'd7;
        rv0 = n_rv;
        feed(2, -1, 0, 1'b0, pp, pq, ok);
        RST = 1'b1;
        step();
        checks += 9;
        if (BUSY !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", BUSY); end
        if (IN_READY !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", IN_READY); end
        if (RES !== 48'd0) begin failures++; $display("FAIL rst_res got=%0d exp=0", RES); end
        if (DSP_OPMODE !== 8'h00) begin failures++; $display("FAIL rst_opmode got=%0h exp=0", DSP_OPMODE); end
        if ({DSP_CEA, DSP_CEB, DSP_CEM, DSP_CEP, DSP_CEOPMODE} !== 5'b0) begin
            failures++; $display("FAIL rst_ce got=%b exp=00000",
                                 {DSP_CEA, DSP_CEB, DSP_CEM, DSP_CEP, DSP_CEOPMODE});
        end
        if (DSP_RST !== 1'b1) begin failures++; $display("FAIL rst_dsp_rst got=%b exp=1", DSP_RST); end
        RST = 1'b0;
        repeat (6) step();
        if (n_rv - rv0 != 0) begin failures++; $display("FAIL rst_no_rv got=%0d exp=0", n_rv - rv0); end
        op_a[0] = 18'd3; op_b[0] = 18'd3;
        feed(1, -1, 0, 1'b0, pp, pq, ok);
        wait_res(res, lat, busy_after, rv_after);
        if (res !== 48'd9) begin failures++; $display("FAIL rst_next_res got=%0d exp=9", res); end
        if (lat !== int'(MUL_LAT) + 2) begin failures++; $display("FAIL rst_next_latency got=%0d exp=%0d", lat, MUL_LAT + 2); end
    endtask

`ifdef PRE_ADD_EN
    task automatic test_preadd();
        logic [47:0] res, pp, pq;
        int lat;
        logic busy_after, rv_after;
        bit ok;
        op_a[0] = 18'd5; op_b[0] = 18'd2; op_d[0] = 18'd3;
        feed(1, -1, 0, 1'b0, pp, pq, ok);
        wait_res(res, lat, busy_after, rv_after);
        op_d[0] = 18'd0;
        checks += 2;
        if (res !== 48'd25) begin failures++; $display("FAIL preadd_res got=%0d exp=25", res); end
        if (last_opm !== 8'h11) begin failures++; $display("FAIL preadd_opmode got=%0h exp=11", last_opm); end
    endtask
`endif

    task automatic test_random();
        logic [47:0] res, pp, pq, exp_res;
        int lat, len;
        logic busy_after, rv_after;
        bit ok;
        for (int j = 0; j < 8; j++) begin
            len = int'($urandom_range(24, 1));
            for (int i = 0; i < len; i++) begin
                op_a[i] = 18'($urandom);
                op_b[i] = 18'($urandom);
            end
            exp_res = ref_dot(len);
            feed(len, -1, 0, 1'b1, pp, pq, ok);
            wait_res(res, lat, busy_after, rv_after);
            checks += 3;
            if (res !== exp_res) begin
                failures++; $display("FAIL random_res job=%0d len=%0d got=%0h exp=%0h", j, len, res, exp_res);
            end
            if (lat !== int'(MUL_LAT) + 2) begin
                failures++; $display("FAIL random_latency job=%0d got=%0d exp=%0d", j, lat, MUL_LAT + 2);
            end
            if (busy_after !== 1'b0) begin
                failures++; $display("FAIL random_busy_low job=%0d got=%b exp=0", j, busy_after);
            end
        end
    endtask

    initial begin
        RST = 1'b1; START = 1'b0; IN_VALID = 1'b0; LEN = '0; IN_A = '0; IN_B = '0;
`ifdef PRE_ADD_EN
        IN_D = '0;
`endif
        for (int i = 0; i < 256; i++) op_d[i] = '0;
        test_reset();
        test_basic();
        test_gap();
        test_len0();
        test_back_to_back();
        test_rst_drain();
`ifdef PRE_ADD_EN
        test_preadd();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
